// File: rtl/multicycle_sequencer_if.sv
// Memory request/ready port between the multicycle sequencer and the memory.
// The master drives the request; the slave answers with ready/rdata.
interface multicycle_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_we, output mem_addr_sel,
                    input  mem_ready, input mem_rdata);
    modport slave  (input  mem_req, input mem_we, input mem_addr_sel,
                    output mem_ready, output mem_rdata);
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle main FSM for the MIPS-subset core: fetch over req/ready, decode,
// branch/jump resolution, and per-state datapath strobes.
module multicycle_sequencer #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multicycle_sequencer_if.master        mem,
    input  logic                          alu_zero,
    input  logic [31:0]                   rs_data,
    output logic [31:0]                   pc,
    output logic [31:0]                   ir,
    output logic [31:0]                   mdr,
    output logic                          reg_we,
    output logic [1:0]                    wb_sel,
    output logic [1:0]                    dst_sel,
    output logic [2:0]                    state_o,
    output logic                          trap
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
        MEM = 3'd4, WB = 3'd5, TRAP = 3'd6
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  wait_cnt;
    logic        req, we, addr_sel;

    logic [5:0]  op, funct;
    logic        is_r, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw;
    logic        supported, ctrl_flow, br_taken;
    logic [31:0] br_off, j_target;

    assign op       = ir[31:26];
    assign funct    = ir[5:0];
    assign br_off   = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign j_target = {pc[31:28], ir[25:0], 2'b00};

    always_comb begin
        is_r = 1'b0; is_jr = 1'b0; is_j = 1'b0; is_jal = 1'b0;
        is_beq = 1'b0; is_bne = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
        supported = 1'b1;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: is_r = 1'b1;
                    6'h08:        is_jr = 1'b1;
                    default:      supported = 1'b0;
                endcase
            end
            6'h02: is_j   = 1'b1;
            6'h03: is_jal = 1'b1;
            6'h04: is_beq = 1'b1;
            6'h05: is_bne = 1'b1;
            6'h23: is_lw  = 1'b1;
            6'h2B: is_sw  = 1'b1;
            6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: ;
            default: supported = 1'b0;
        endcase
    end

    assign ctrl_flow = is_j | is_jal | is_jr | is_beq | is_bne;
    assign br_taken  = (is_beq & alu_zero) | (is_bne & ~alu_zero);

    always_comb begin
        state_n  = state;
        req      = 1'b0;
        we       = 1'b0;
        addr_sel = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 2'b00;
        dst_sel  = 2'b00;
        case (state)
            IDLE:   state_n = FETCH;
            FETCH: begin
                req = 1'b1;
                if (mem.mem_ready)          state_n = DECODE;
                else if (wait_cnt == TMO_LAST) state_n = TRAP;
            end
            DECODE: state_n = supported ? EXEC : TRAP;
            EXEC: begin
                // jal writes the return address while pc still holds it
                if (is_jal) begin
                    reg_we  = 1'b1;
                    wb_sel  = 2'b10;
                    dst_sel = 2'b10;
                end
                if (ctrl_flow)           state_n = FETCH;
                else if (is_lw || is_sw) state_n = MEM;
                else                     state_n = WB;
            end
            MEM: begin
                req      = 1'b1;
                addr_sel = 1'b1;
                we       = is_sw;
                if (mem.mem_ready)          state_n = is_lw ? WB : FETCH;
                else if (wait_cnt == TMO_LAST) state_n = TRAP;
            end
            WB: begin
                reg_we  = 1'b1;
                wb_sel  = is_lw ? 2'b01 : 2'b00;
                dst_sel = is_r  ? 2'b01 : 2'b00;
                state_n = FETCH;
            end
            TRAP:    state_n = TRAP;
            default: state_n = TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= PC_RESET;
            ir       <= '0;
            mdr      <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_n;
            // counter restarts whenever a new state (FETCH/MEM included) is entered
            if (state_n != state)              wait_cnt <= '0;
            else if (req && !mem.mem_ready)    wait_cnt <= wait_cnt + 8'd1;

            if (state == FETCH && mem.mem_ready) begin
                ir <= mem.mem_rdata;
                pc <= pc + 32'd4;
            end
            if (state == EXEC) begin
                if (is_j || is_jal) pc <= j_target;
                else if (is_jr)     pc <= rs_data;
                else if (br_taken)  pc <= pc + br_off;
            end
            if (state == MEM && mem.mem_ready && is_lw) mdr <= mem.mem_rdata;
        end
    end

    assign mem.mem_req      = req;
    assign mem.mem_we       = we;
    assign mem.mem_addr_sel = addr_sel;
    assign state_o          = state;
    assign trap             = (state == TRAP);
endmodule
